// File: rtl/run_monitor.sv
// Finish detection, run counters and an in-order store-trace FIFO for the pipelined core.
// Gating outputs are combinational from pc; counters and trace state update one edge later.
module run_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      pc_finished,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  input  logic             flushD,
  input  logic             stallD,
  output logic             finish,
  output logic             cpu_en,
  output logic             dmem_we,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_addr,
  output logic [31:0]      trace_data,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic          hit;
  logic          done_r;
  logic          running;
  logic          store_acc;
  logic          pop;
  logic          push;
  logic          full;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   occ;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   last_head;
  logic [63:0]   head;

  assign hit       = (pc == pc_finished);
  assign finish    = done_r | hit;
  assign cpu_en    = ~finish;
  assign dmem_we   = memwrite & ~finish;
  assign running   = ~finish;
  assign store_acc = running & memwrite;

  assign trace_valid = (occ != '0);
  assign full        = (occ == FULL_OCC);
  assign pop         = trace_valid & trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push        = store_acc & (~full | pop);

  assign head       = trace_valid ? mem[rd_ptr] : last_head;
  assign trace_addr = head[63:32];
  assign trace_data = head[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      done_r    <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      store_cnt <= '0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      last_head <= '0;
    end else begin
      if (hit)
        done_r <= 1'b1;
      if (running && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (running && !flushD && !stallD && instr_cnt != '1)
        instr_cnt <= instr_cnt + 1'b1;
      if (store_acc && store_cnt != '1)
        store_cnt <= store_cnt + 1'b1;
      if (store_acc && !push)
        overflow <= 1'b1;
      if (trace_valid)
        last_head <= mem[rd_ptr];
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        occ <= occ + 1'b1;
      else if (pop && !push)
        occ <= occ - 1'b1;
    end
  end

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {dataadr, writedata};
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run monitor that sits between the pipelined `mips` core and `dmem`, alongside them. It detects program completion when `pc` reaches a programmed finish address and gates the core and store path off. It counts cycles, retired-decode instructions and stores, and captures every accepted store (address, data) into a FIFO for in-order drain by a checker. It replaces behavioural finish, CPI and store-trace logic with hardware usable on the bench and on FPGA.

## Interface
Parameters:
- `DEPTH`, 16: trace FIFO entries; power of two, ≥2.
- `CNT_W`, 32: width of each counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  32  core fetch PC.
- `pc_finished`  in  32  finish address; held stable during a run.
- `memwrite`  in  1  core store strobe.
- `dataadr`  in  32  core store address (`aluout`).
- `writedata`  in  32  core store data.
- `flushD`  in  1  decode flush from the datapath.
- `stallD`  in  1  decode stall from the hazard unit.
- `finish`  out  1  run complete, combinational with sticky hold.
- `cpu_en`  out  1  `~finish`; core clock enable.
- `dmem_we`  out  1  `memwrite & ~finish`; the write enable to `dmem`.
- `cycle_cnt`  out  CNT_W  cycles while running.
- `instr_cnt`  out  CNT_W  decode-accepted instructions.
- `store_cnt`  out  CNT_W  accepted stores, including dropped ones.
- `trace_valid`  out  1  FIFO non-empty.
- `trace_ready`  in  1  consumer accepts head entry.
- `trace_addr`  out  32  head entry address.
- `trace_data`  out  32  head entry data.
- `overflow`  out  1  sticky; a store was dropped because the FIFO was full.

## Operation
- `hit = (pc == pc_finished)`.
- `done_r` sets on the first edge where `hit` = 1. It clears only on `reset`.
- `finish = done_r | hit`. Later changes to `pc` or `pc_finished` never deassert `finish` once `done_r` is set.
- Running cycle is any cycle with `finish` = 0.
- `cycle_cnt` increments by 1 on each running cycle.
- `instr_cnt` increments on a running cycle when `~flushD & ~stallD`.
- Accepted store is a running cycle with `memwrite` = 1.
  - `store_cnt` increments on every accepted store.
  - The store is pushed as {`dataadr`, `writedata`} if the FIFO is not full after this cycle's pop.
- Counters saturate at all-ones and never wrap.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits plus a separate occupancy count (0..DEPTH).
  - Pop when `trace_valid & trace_ready`.
  - `trace_addr`/`trace_data` present the head entry whenever `trace_valid` = 1. They hold the last head value when the FIFO is empty.
- Boundaries:
  - Full with simultaneous pop and push: both occur; occupancy stays at DEPTH.
  - Full with push and no pop: entry dropped, `overflow` sets, `store_cnt` still increments.
  - Empty with push: no bypass; `trace_valid` rises the following cycle.
  - Pointers wrap modulo DEPTH.
  - Drain continues after `finish`; only pushes and counting stop.
  - Reset mid-run or mid-drain: FIFO emptied, all counters and flags cleared, entries discarded.

## Timing
- Reset values:
  - `done_r`, all counters, occupancy, pointers, `overflow` = 0.
  - `trace_valid` = 0.
  - `trace_addr`/`trace_data` = 0.
  - `finish` = `hit` and `cpu_en` = `~hit`, both combinational.
- `finish`, `cpu_en`, `dmem_we`: zero-latency combinational from `pc`.
  - The store issued in the cycle where `hit` first rises is suppressed.
- Counters, `overflow`, `trace_valid`: registered, updated one edge after the qualifying cycle.
- Push-to-`trace_valid` latency: 1 cycle. Pop takes effect at the same edge; the next head appears the following cycle.
- Throughput: 1 push and 1 pop per cycle.

## Test plan
- Reset with `pc_finished`=0xFFFFFFFF, then 10 running cycles with `flushD`=`stallD`=0 -> `cycle_cnt`=10, `instr_cnt`=10, `finish`=0, `trace_valid`=0.
- Stores {0x54,7} then {0x50,0xAB} with `trace_ready`=0, then `trace_ready`=1 -> entries drain in order as (0x54,7), (0x50,0xAB); `store_cnt`=2; `trace_valid` drops after the second pop.
- 6 running cycles with `stallD`=1 on 2 of them and `flushD`=1 on 1 -> `cycle_cnt`=6, `instr_cnt`=3.
- `pc` driven to `pc_finished`=0x3C together with `memwrite`=1 -> `finish`=1 and `dmem_we`=0 in that cycle; no push; counters frozen. Afterwards `pc`=0x40 -> `finish` stays 1.
- DEPTH=16, `trace_ready`=0, 17 stores -> occupancy 16, `overflow`=1, `store_cnt`=17. The 17th store pushed together with a pop when full -> accepted, occupancy stays 16.
- Reset asserted mid-drain with 5 entries queued -> next cycle `trace_valid`=0, `overflow`=0, all counters 0.
